// File: rtl/core_dmem_bridge.sv
// Data-memory bridge between the MEM stage and a handshaked bus: store buffer
// that drains in the background plus an in-order, stalling load engine.
//   state   | meaning
//   S_IDLE  | accepting new accesses from the MEM stage
//   S_DRAIN | load pending, emptying the store buffer first
//   S_LREQ  | load request on the bus, waiting for bus_gnt
//   S_LWAIT | load granted, waiting for bus_rvalid
//   S_DONE  | load data in mem_rd, pipeline advances
module core_dmem_bridge #(
  parameter int ADDR_W   = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wd,
  output logic [31:0]       mem_rd,
  output logic              mem_stall,
  output logic              misaligned_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wd,
  output logic [3:0]        bus_be,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(SB_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_LREQ, S_LWAIT, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
  logic [3:0]        sb_be_q   [SB_DEPTH];
  logic [31:0]       sb_data_q [SB_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, cnt_after_pop;

  logic              bus_req_q, bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [31:0]       bus_wd_q, mem_rd_q;
  logic [3:0]        bus_be_q;

  logic              is_byte, is_half, aligned, full, idle_acc;
  logic              load_go, push, pop, issue_load, store_ok, bus_free;
  logic [3:0]        acc_be;
  logic [31:0]       acc_wd, rd_shift, ld_ext;
  logic [ADDR_W-1:0] word_addr;

  assign is_byte   = (mem_size == 2'b00);
  assign is_half   = (mem_size == 2'b01);
  assign aligned   = !(is_half && mem_addr[0]) && !(mem_size[1] && (mem_addr[1:0] != 2'b00));
  assign word_addr = {mem_addr[ADDR_W-1:2], 2'b00};
  assign full      = (count_q == FULL_CNT);

  always_comb begin
    acc_be = 4'b1111;
    acc_wd = mem_wd;
    if (is_byte) begin
      acc_be = 4'b0001 << mem_addr[1:0];
      acc_wd = {4{mem_wd[7:0]}};
    end else if (is_half) begin
      acc_be = 4'b0011 << {mem_addr[1], 1'b0};
      acc_wd = {2{mem_wd[15:0]}};
    end
  end

  // Accesses are only decoded in IDLE; in DONE the inputs still show the finished load.
  assign idle_acc       = !reset && (state_q == S_IDLE) && mem_req;
  assign misaligned_err = idle_acc && !aligned;
  assign load_go        = idle_acc && aligned && !mem_we;
  assign push           = idle_acc && aligned && mem_we && !full;
  assign mem_stall      = !reset && (load_go || (idle_acc && aligned && mem_we && full) ||
                                     (state_q inside {S_DRAIN, S_LREQ, S_LWAIT}));

  assign pop           = bus_req_q && bus_we_q && bus_gnt;
  assign cnt_after_pop = count_q - {{PW{1'b0}}, pop};
  assign rd_ptr_d      = rd_ptr_q + {{(PW-1){1'b0}}, pop};
  assign issue_load    = (load_go && (count_q == '0)) ||
                         ((state_q == S_DRAIN) && (cnt_after_pop == '0));
  assign store_ok      = !issue_load && (state_q != S_LREQ) && (state_q != S_LWAIT);
  assign bus_free      = !bus_req_q || bus_gnt;

  assign rd_shift = bus_rdata >> {mem_addr[1:0], 3'b000};
  always_comb begin
    ld_ext = bus_rdata;
    if (is_byte)      ld_ext = {{24{!mem_unsigned && rd_shift[7]}}, rd_shift[7:0]};
    else if (is_half) ld_ext = {{16{!mem_unsigned && rd_shift[15]}}, rd_shift[15:0]};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr_q[wr_ptr_q] <= word_addr;
      sb_be_q[wr_ptr_q]   <= acc_be;
      sb_data_q[wr_ptr_q] <= acc_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      bus_req_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_addr_q <= '0;
      bus_wd_q   <= '0;
      bus_be_q   <= '0;
      mem_rd_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + {{(PW-1){1'b0}}, push};
      rd_ptr_q <= rd_ptr_d;
      count_q  <= cnt_after_pop + {{PW{1'b0}}, push};

      case (state_q)
        S_IDLE: begin
          if (load_go) begin
            if (count_q == '0) state_q <= S_LREQ;
            else               state_q <= S_DRAIN;
          end
        end
        S_DRAIN: if (cnt_after_pop == '0) state_q <= S_LREQ;
        S_LREQ:  if (bus_gnt) state_q <= S_LWAIT;
        S_LWAIT: begin
          if (bus_rvalid) begin
            mem_rd_q <= ld_ext;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // The bus register only reloads once the current request has been granted.
      if (bus_free) begin
        if (issue_load) begin
          bus_req_q  <= 1'b1;
          bus_we_q   <= 1'b0;
          bus_addr_q <= word_addr;
          bus_wd_q   <= '0;
          bus_be_q   <= acc_be;
        end else if (store_ok && (cnt_after_pop != '0)) begin
          bus_req_q  <= 1'b1;
          bus_we_q   <= 1'b1;
          bus_addr_q <= sb_addr_q[rd_ptr_d];
          bus_wd_q   <= sb_data_q[rd_ptr_d];
          bus_be_q   <= sb_be_q[rd_ptr_d];
        end else if (store_ok && push) begin
          bus_req_q  <= 1'b1;
          bus_we_q   <= 1'b1;
          bus_addr_q <= word_addr;
          bus_wd_q   <= acc_wd;
          bus_be_q   <= acc_be;
        end else begin
          bus_req_q  <= 1'b0;
          bus_we_q   <= 1'b0;
          bus_addr_q <= '0;
          bus_wd_q   <= '0;
          bus_be_q   <= '0;
        end
      end
    end
  end

  assign bus_req  = bus_req_q;
  assign bus_we   = bus_we_q;
  assign bus_addr = bus_addr_q;
  assign bus_wd   = bus_wd_q;
  assign bus_be   = bus_be_q;
  assign mem_rd   = mem_rd_q;

endmodule
